rpn_sequencer: RTL

- Program-driven initiator for the RPN stack calculator; the calculator is the responder.
- Holds a small instruction memory loaded over a write port and, on start, clears the calculator.
- Replays the program as push/op/step commands to the calculator and reports the final top-of-stack.
- Checks the calculator's stack count before every command and halts with an error instead of letting the calculator silently drop an illegal operation.

---
 rtl/rpn_pkg.sv | 43 ++++
 rtl/rpn_sequencer_if.sv | 23 ++
 rtl/rpn_prog_mem.sv | 28 ++
 rtl/rpn_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types for the RPN program sequencer: instruction kinds (equal to the
// calculator op codes), the packed instruction word, FSM states and the
// calculator stack capacity.
package rpn_pkg;

  localparam int CALC_CAP = 1000;
  localparam int RPN_W    = 16;

  typedef enum logic [1:0] {
    K_PUSH = 2'd0,
    K_NEG  = 2'd1,
    K_ADD  = 2'd2,
    K_MUL  = 2'd3
  } kind_t;

  typedef struct packed {
    kind_t              kind;
    logic [RPN_W-1:0]   imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_t;

  // True when the calculator can accept this kind at the given stack depth.
  function automatic logic op_legal(input kind_t k, input logic [9:0] cnt, input int cap);
    logic ok;
    case (k)
      K_PUSH:  ok = (int'(cnt) < cap);
      K_NEG:   ok = (cnt >= 10'd1);
      default: ok = (cnt >= 10'd2);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Command/status bus between the sequencer (master) and the RPN calculator
// (slave).
interface rpn_sequencer_if #(
  parameter int W = 16
);
  logic         calc_nrst;
  logic         calc_step;
  logic         calc_push;
  logic [W-1:0] calc_d;
  logic [1:0]   calc_op;
  logic [W-1:0] calc_out;
  logic [9:0]   calc_cnt;

  modport master (
    output calc_nrst, calc_step, calc_push, calc_d, calc_op,
    input  calc_out, calc_cnt
  );

  modport slave (
    input  calc_nrst, calc_step, calc_push, calc_d, calc_op,
    output calc_out, calc_cnt
  );
endinterface

// File: rtl/rpn_prog_mem.sv
// Program store: one synchronous write port, one synchronous read port with
// enable. No reset, so the program survives a sequencer reset.
module rpn_prog_mem #(
  parameter int DEPTH = 64,
  parameter int DW    = 18
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; rdata holds between reads so the fetched word stays put.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Program-driven initiator for the RPN calculator. Loads a program, clears
// the calculator on start, then replays each instruction as a 4-cycle
// FETCH/CHECK/ISSUE/RELEASE sequence, refusing any command the calculator
// would have to drop given its current stack depth.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  parameter int CAP   = CALC_CAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [W+1:0]             ld_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  rpn_sequencer_if.master          calc,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             result,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   err_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  state_t         state_reg, state_next;
  logic [PW-1:0]  pc_reg, len_reg;
  logic [PW-1:0]  pc_inc, len_sat;
  logic [W+1:0]   rd_data;
  logic           cmd_valid_reg;
  logic           calc_nrst_reg, calc_step_reg;
  logic [W-1:0]   result_reg;
  logic [PW-1:0]  err_pc_reg;
  kind_t          cur_kind;
  logic           cur_legal;
  logic           idle_like;
  logic           mem_we, mem_re;

  assign idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR);
  assign busy      = !idle_like;
  assign done      = (state_reg == S_DONE);
  assign err       = (state_reg == S_ERR);
  assign result    = result_reg;
  assign err_pc    = err_pc_reg;

  assign pc_inc  = pc_reg + PW'(1);
  assign len_sat = (len > PW'(DEPTH)) ? PW'(DEPTH) : len;

  assign mem_we = ld_we && !busy;
  assign mem_re = (state_reg == S_FETCH);

  rpn_prog_mem #(
    .DEPTH (DEPTH),
    .DW    (W + 2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (mem_re),
    .raddr (pc_reg[AW-1:0]),
    .rdata (rd_data)
  );

  assign cur_kind  = kind_t'(rd_data[W+1:W]);
  assign cur_legal = op_legal(cur_kind, calc.calc_cnt, CAP);

  // The fetched word sits in the read register from CHECK until the next
  // FETCH, so the command fields are stable across ISSUE and RELEASE.
  // cmd_valid_reg masks the unloaded register after reset / start.
  assign calc.calc_nrst = calc_nrst_reg;
  assign calc.calc_step = calc_step_reg;
  assign calc.calc_push = cmd_valid_reg && (cur_kind == K_PUSH);
  assign calc.calc_d    = cmd_valid_reg ? rd_data[W-1:0] : '0;
  assign calc.calc_op   = cmd_valid_reg ? rd_data[W+1:W] : 2'd0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_CLEAR;
      S_CLEAR:   state_next = (len_reg == '0) ? S_DONE : S_FETCH;
      S_FETCH:   state_next = S_CHECK;
      S_CHECK:   state_next = cur_legal ? S_ISSUE : S_ERR;
      S_ISSUE:   state_next = S_RELEASE;
      S_RELEASE: state_next = (pc_inc == len_reg) ? S_DONE : S_FETCH;
      default:   state_next = S_IDLE;
    endcase
  end

  // Datapath registers: pc, len, strobes, result and error index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg        <= '0;
      len_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      calc_nrst_reg <= 1'b1;
      calc_step_reg <= 1'b0;
      result_reg    <= '0;
      err_pc_reg    <= '0;
    end else begin
      // Strobes come straight from flops, decoded from the next state.
      calc_nrst_reg <= (state_next != S_CLEAR);
      calc_step_reg <= (state_next == S_ISSUE);
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            len_reg       <= len_sat;
            pc_reg        <= '0;
            err_pc_reg    <= '0;
            cmd_valid_reg <= 1'b0;
          end
        end
        S_CLEAR: begin
          pc_reg <= '0;
          // The calculator clears on this same edge, so its old top-of-stack
          // is still visible here; an empty program reports the cleared 0.
          if (len_reg == '0) result_reg <= '0;
        end
        S_FETCH: cmd_valid_reg <= 1'b1;
        S_CHECK: if (!cur_legal) err_pc_reg <= pc_reg;
        S_RELEASE: begin
          pc_reg <= pc_inc;
          if (pc_inc == len_reg) result_reg <= calc.calc_out;
        end
        default: ;
      endcase
    end
  end

endmodule
